alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage arithmetic block for the single-cycle 32-bit MIPS-subset CPU. It contains three functions:
- the ALU-control decoder, which maps the main controller's 2-bit ALU op and the instruction funct field to a 4-bit ALU operation code;
- the 32-bit ALU, which produces a result and a zero flag;
- a standalone 32-bit adder, used for PC+4 and for the branch-target add.

All three are combinational. A small capture register holds the last ALU result and zero flag for debug and trace.

## Interface
Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; the capture register updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the capture register.
- alu_op  in  2  ALU op from the main controller.
- funct  in  6  instruction bits [5:0].
- shamt  in  5  instruction bits [10:6].
- a  in  32  ALU operand A (rs data).
- b  in  32  ALU operand B (rt data or sign-extended immediate).
- add_a  in  32  adder operand A.
- add_b  in  32  adder operand B.
- alu_ctrl  out  4  decoded operation code.
- result  out  32  ALU result (combinational).
- zero  out  1  high when result == 0 (combinational).
- sum  out  32  add_a + add_b, modulo 2^32 (combinational).
- result_q  out  32  registered result; 0 after reset.
- zero_q  out  1  registered zero; 1 after reset.

## Operation
ALU-control decode:
- alu_op 00 → ADD 0010 (lw/sw address).
- alu_op 01 → SUB 0110 (beq compare).
- alu_op 11 → ADD 0010.
- alu_op 10 → decode funct as follows:
  - 100000 add → 0010
  - 100010 sub → 0110
  - 100100 and → 0000
  - 100101 or → 0001
  - 100111 nor → 1100
  - 101010 slt → 0111
  - 000000 sll → 1000
  - 000010 srl → 1001
  - any other funct → 0010 (ADD).

ALU operations:
- 0000 → a & b.
- 0001 → a | b.
- 0010 → a + b, wrapping, no overflow detection.
- 0110 → a − b, wrapping.
- 0111 → signed compare: result = 1 if $signed(a) < $signed(b), else 0. The compare must be correct when a − b overflows, e.g. a=0x7FFFFFFF, b=0x80000000 gives 0.
- 1100 → ~(a | b).
- 1000 → b << shamt, logical.
- 1001 → b >> shamt, logical, zero fill.
- Any other code → result 0.

Zero flag:
- zero is derived from the final result for every operation, not only for SUB.

Adder:
- sum = add_a + add_b.
- Carry-out is discarded.
- The adder is independent of the ALU path.

## Timing
- alu_ctrl, result, zero and sum are purely combinational, with zero cycle latency. They settle within the same cycle as their inputs.
- Capture register: on posedge clk with reset low, result_q ← result and zero_q ← zero.
- reset asserted at any time forces result_q = 0 and zero_q = 1 immediately. Capture holds while reset is high and resumes on the first rising edge after reset deasserts.
- reset has no effect on the combinational outputs.
- The CPU updates its PC on the falling edge. The combinational paths must therefore settle within half a clock period.

## Structure
Shared package holds:
- ALU op constants: ALUOP_MEM=00, ALUOP_BEQ=01, ALUOP_R=10.
- Funct constants.
- 4-bit ALU code constants: AND, OR, ADD, SUB, SLT, NOR, SLL, SRL.

Sub-modules:
- Decode is one sub-module, alu_exec_ctrl.
- The adder is one reusable sub-module, alu_exec_add, instantiated once here and reusable for the branch adder elsewhere.
- The ALU core, zero flag and capture register live in the top module.

## Test plan
- Decode sweep: alu_op 00 and 01 with random funct → 0010 and 0110. alu_op 10 with each listed funct → the listed code. alu_op 10, funct 111111 → 0010.
- Arithmetic:
  - a=30, b=20, ADD → result 50, zero 0.
  - SUB with a=b=70 → result 0, zero 1.
  - SUB with a=0, b=1 → result 0xFFFFFFFF.
- Logic and compare:
  - a=0xF0F0F0F0, b=0x0FF00FF0 → AND 0x00F000F0, OR 0xFFF0FFF0, NOR 0x000F000F.
  - SLT with a=−5, b=3 → 1.
  - SLT with a=0x7FFFFFFF, b=0x80000000 → 0.
- Shifts:
  - b=0x80000001, shamt=4 → SLL 0x00000010, SRL 0x08000000.
  - shamt=0 → result equals b.
- Adder:
  - add_a=0x00000040, add_b=4 → sum 0x44.
  - add_a=0xFFFFFFFC, add_b=4 → sum 0 (wrap).
- Capture and reset:
  - Assert reset mid-run → result_q=0 and zero_q=1 without waiting for a clock edge.
  - After release, the next posedge captures result 50 and zero 0 from the ADD case.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: controller ALU ops, R-type funct codes
// and the 4-bit operation codes consumed by the ALU core.
package alu_exec_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

endpackage

// File: rtl/alu_exec_add.sv
// Reusable modulo-2^WIDTH adder (PC+4, branch target). Carry-out is dropped.
module alu_exec_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU-control decoder: maps the controller's ALU op and the funct field to an
// ALU operation code. Purely combinational.
module alu_exec_ctrl
  import alu_exec_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [3:0] aluCtrl
);

  always_comb begin
    aluCtrl = ALU_ADD;
    unique case (aluOp)
      ALUOP_MEM: aluCtrl = ALU_ADD;
      ALUOP_BEQ: aluCtrl = ALU_SUB;
      ALUOP_IMM: aluCtrl = ALU_ADD;
      ALUOP_R: begin
        // Unlisted funct values fall back to ADD so the datapath never sees an
        // undefined operation.
        case (funct)
          FUNCT_ADD: aluCtrl = ALU_ADD;
          FUNCT_SUB: aluCtrl = ALU_SUB;
          FUNCT_AND: aluCtrl = ALU_AND;
          FUNCT_OR:  aluCtrl = ALU_OR;
          FUNCT_NOR: aluCtrl = ALU_NOR;
          FUNCT_SLT: aluCtrl = ALU_SLT;
          FUNCT_SLL: aluCtrl = ALU_SLL;
          FUNCT_SRL: aluCtrl = ALU_SRL;
          default:   aluCtrl = ALU_ADD;
        endcase
      end
      default: aluCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: ALU-control decode, 32-bit ALU with zero flag, standalone adder,
// and a debug capture register of the last ALU result.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  logic signed [WIDTH-1:0] aSigned;
  logic signed [WIDTH-1:0] bSigned;
  logic                    lessThan;

  alu_exec_ctrl ctrlInst (
    .aluOp   (alu_op),
    .funct   (funct),
    .aluCtrl (alu_ctrl)
  );

  alu_exec_add #(.WIDTH(WIDTH)) addInst (
    .a   (add_a),
    .b   (add_b),
    .sum (sum)
  );

  // Native signed compare rather than the sign of a-b, so overflow cannot flip it.
  assign aSigned  = a;
  assign bSigned  = b;
  assign lessThan = aSigned < bSigned;

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lessThan};
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Capture stage: debug/trace copy of the combinational ALU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a, b, add_a, add_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result, sum, result_q;
  logic        zero, zero_q;

  typedef struct {
    string       name;
    int          sel;   // 0 ctrl, 1 result, 2 zero, 3 sum, 4 result_q, 5 zero_q
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .funct    (funct),
    .shamt    (shamt),
    .a        (a),
    .b        (b),
    .add_a    (add_a),
    .add_b    (add_b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .sum      (sum),
    .result_q (result_q),
    .zero_q   (zero_q)
  );

  // Monitor: outputs are considered presented at every falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = {28'b0, alu_ctrl};
        1:       act = result;
        2:       act = {31'b0, zero};
        3:       act = sum;
        4:       act = result_q;
        default: act = {31'b0, zero_q};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic rop(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                     input logic [4:0] sh);
    alu_op = 2'b10;
    funct  = f;
    a      = av;
    b      = bv;
    shamt  = sh;
  endtask

  typedef struct {
    logic [5:0] f;
    logic [3:0] code;
  } dec_t;

  dec_t decTab[9] = '{
    '{6'b100000, 4'b0010}, '{6'b100010, 4'b0110}, '{6'b100100, 4'b0000},
    '{6'b100101, 4'b0001}, '{6'b100111, 4'b1100}, '{6'b101010, 4'b0111},
    '{6'b000000, 4'b1000}, '{6'b000010, 4'b1001}, '{6'b111111, 4'b0010}
  };

  initial begin
    reset = 1'b1;
    alu_op = 2'b00; funct = '0; shamt = '0;
    a = '0; b = '0; add_a = '0; add_b = '0;

    // Reset state
    #2;
    push("reset_result_q", 4, 32'h0);
    push("reset_zero_q", 5, 32'h1);
    step();
    reset = 1'b0;

    // Decode sweep
    for (int i = 0; i < 4; i++) begin
      step();
      alu_op = 2'b00; funct = 6'($urandom_range(0, 63));
      push("dec_op00", 0, 32'h2);
      step();
      alu_op = 2'b01; funct = 6'($urandom_range(0, 63));
      push("dec_op01", 0, 32'h6);
      step();
      alu_op = 2'b11; funct = 6'($urandom_range(0, 63));
      push("dec_op11", 0, 32'h2);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      alu_op = 2'b10; funct = decTab[i].f;
      push($sformatf("dec_funct_%b", decTab[i].f), 0, {28'b0, decTab[i].code});
    end

    // Arithmetic
    step(); rop(6'b100010, 32'd70, 32'd70, 5'd0);
    push("sub_eq_res", 1, 32'h0);            push("sub_eq_zero", 2, 32'h1);
    step(); rop(6'b100010, 32'd0, 32'd1, 5'd0);
    push("sub_neg_res", 1, 32'hFFFF_FFFF);   push("sub_neg_zero", 2, 32'h0);
    step(); alu_op = 2'b01; a = 32'd9; b = 32'd4;
    push("beq_sub_res", 1, 32'h5);

    // Logic and compare
    step(); rop(6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    push("and_res", 1, 32'h00F0_00F0);       push("and_zero", 2, 32'h0);
    step(); rop(6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    push("or_res", 1, 32'hFFF0_FFF0);
    step(); rop(6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    push("nor_res", 1, 32'h000F_000F);
    step(); rop(6'b100100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0);
    push("and_empty_res", 1, 32'h0);         push("and_empty_zero", 2, 32'h1);
    step(); rop(6'b101010, 32'hFFFF_FFFB, 32'd3, 5'd0);
    push("slt_neg_res", 1, 32'h1);           push("slt_neg_zero", 2, 32'h0);
    step(); rop(6'b101010, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0);
    push("slt_ovf_res", 1, 32'h0);           push("slt_ovf_zero", 2, 32'h1);
    step(); rop(6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0);
    push("slt_ovf2_res", 1, 32'h1);

    // Shifts
    step(); rop(6'b000000, 32'h1234_5678, 32'h8000_0001, 5'd4);
    push("sll4_res", 1, 32'h0000_0010);
    step(); rop(6'b000010, 32'h1234_5678, 32'h8000_0001, 5'd4);
    push("srl4_res", 1, 32'h0800_0000);
    step(); rop(6'b000000, 32'h0, 32'hA5A5_0003, 5'd0);
    push("sll0_res", 1, 32'hA5A5_0003);
    step(); rop(6'b000010, 32'h0, 32'hA5A5_0003, 5'd0);
    push("srl0_res", 1, 32'hA5A5_0003);
    step(); rop(6'b000010, 32'h0, 32'h8000_0000, 5'd31);
    push("srl31_res", 1, 32'h1);

    // Adder, independent of the ALU inputs
    step(); add_a = 32'h0000_0040; add_b = 32'd4;
    push("add_pc4", 3, 32'h44);
    step(); add_a = 32'hFFFF_FFFC; add_b = 32'd4;
    push("add_wrap", 3, 32'h0);

    // Capture and reset
    step(); rop(6'b100000, 32'd30, 32'd20, 5'd0);
    push("add_res", 1, 32'd50);              push("add_zero", 2, 32'h0);
    step();
    push("cap_res_q", 4, 32'd50);            push("cap_zero_q", 5, 32'h0);
    step(); reset = 1'b1; #1;
    push("async_reset_res_q", 4, 32'h0);     push("async_reset_zero_q", 5, 32'h1);
    push("reset_comb_res", 1, 32'd50);
    step();
    push("hold_reset_res_q", 4, 32'h0);      push("hold_reset_zero_q", 5, 32'h1);
    reset = 1'b0;
    step();
    push("release_res_q", 4, 32'd50);        push("release_zero_q", 5, 32'h0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
